mat_store_responder: RTL

- Two-slot matrix storage; the responder side of the matrix read port used by the transpose and other matrix operators.
- Accepts a row-major element stream on a write port and commits it into a slot together with its dimensions.
- Serves single-element reads addressed by (slot, row, col) with fixed one-cycle latency.
- Provides per-slot valid and dimension status to the operator front-ends.

---
 rtl/mat_store_responder_if.sv | 41 ++++
 rtl/mat_store_responder.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mat_store_responder_if.sv
// Bundle of the matrix store write port, read port and slot status lines.
// The slave modport is the storage responder; master is the driving operator/front-end.
interface mat_store_responder_if #(
  parameter int DIM_WIDTH  = 3,
  parameter int DATA_WIDTH = 8
);
  logic                  wr_start;
  logic                  wr_slot;
  logic [DIM_WIDTH-1:0]  wr_m;
  logic [DIM_WIDTH-1:0]  wr_n;
  logic                  wr_elem_valid;
  logic [DATA_WIDTH-1:0] wr_elem;
  logic                  wr_busy;
  logic                  wr_done;
  logic                  wr_error;
  logic                  rd_en;
  logic                  rd_slot_idx;
  logic [DIM_WIDTH-1:0]  rd_row_idx;
  logic [DIM_WIDTH-1:0]  rd_col_idx;
  logic [DATA_WIDTH-1:0] rd_elem;
  logic                  rd_elem_valid;
  logic                  rd_err;
  logic [1:0]            slot_valid;
  logic                  q_slot;
  logic [DIM_WIDTH-1:0]  q_m;
  logic [DIM_WIDTH-1:0]  q_n;

  modport slave (
    input  wr_start, wr_slot, wr_m, wr_n, wr_elem_valid, wr_elem,
    input  rd_en, rd_slot_idx, rd_row_idx, rd_col_idx, q_slot,
    output wr_busy, wr_done, wr_error, rd_elem, rd_elem_valid, rd_err,
    output slot_valid, q_m, q_n
  );

  modport master (
    output wr_start, wr_slot, wr_m, wr_n, wr_elem_valid, wr_elem,
    output rd_en, rd_slot_idx, rd_row_idx, rd_col_idx, q_slot,
    input  wr_busy, wr_done, wr_error, rd_elem, rd_elem_valid, rd_err,
    input  slot_valid, q_m, q_n
  );
endinterface

// File: rtl/mat_store_responder.sv
// Two-slot matrix store: row-major stream loader with commit/validate, and a
// one-cycle-latency (slot,row,col) element read port with bounds checking.
//
// state  | meaning
// W_IDLE | waiting for wr_start
// W_FILL | accepting row-major elements into the latched slot
// W_DONE | commit dims and set slot_valid (wr_done high)
// W_ERR  | load rejected for illegal dims (wr_error high)
module mat_store_responder #(
  parameter int DIM_WIDTH  = 3,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DIM    = 5
) (
  input logic clk,
  input logic rst_n,
  mat_store_responder_if.slave bus
);
  localparam int DEPTH  = MAX_DIM * MAX_DIM;
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_FILL = 2'd1;
  localparam logic [1:0] W_DONE = 2'd2;
  localparam logic [1:0] W_ERR  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  slot_q;
  logic [DIM_WIDTH-1:0]  m_q, n_q, row_q, col_q;
  logic [DIM_WIDTH-1:0]  dim_m_q [2];
  logic [DIM_WIDTH-1:0]  dim_n_q [2];
  logic [1:0]            slot_valid_q;
  logic [DATA_WIDTH-1:0] rd_elem_q;
  logic                  rd_valid_q, rd_err_q;
  logic [DATA_WIDTH-1:0] mem [2][DEPTH];

  logic                  dims_ok;
  logic                  wr_fire;
  logic                  last_col, last_row;
  logic [ADDR_W-1:0]     wr_addr, rd_addr;
  logic                  rd_ok;

  assign dims_ok  = (bus.wr_m != '0) && (bus.wr_m <= DIM_WIDTH'(MAX_DIM)) &&
                    (bus.wr_n != '0) && (bus.wr_n <= DIM_WIDTH'(MAX_DIM));
  assign wr_fire  = (state_q == W_FILL) && bus.wr_elem_valid;
  assign last_col = (col_q == n_q - DIM_WIDTH'(1));
  assign last_row = (row_q == m_q - DIM_WIDTH'(1));
  assign wr_addr  = ADDR_W'(row_q) * ADDR_W'(MAX_DIM) + ADDR_W'(col_q);
  assign rd_addr  = ADDR_W'(bus.rd_row_idx) * ADDR_W'(MAX_DIM) + ADDR_W'(bus.rd_col_idx);

  // Stored dims never exceed MAX_DIM, so passing the bounds check keeps rd_addr in range.
  assign rd_ok = bus.rd_en && slot_valid_q[bus.rd_slot_idx] &&
                 (bus.rd_row_idx < dim_m_q[bus.rd_slot_idx]) &&
                 (bus.rd_col_idx < dim_n_q[bus.rd_slot_idx]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      W_IDLE: if (bus.wr_start) state_d = dims_ok ? W_FILL : W_ERR;
      W_FILL: if (bus.wr_elem_valid && last_col && last_row) state_d = W_DONE;
      W_DONE: state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= W_IDLE;
      slot_q       <= 1'b0;
      m_q          <= '0;
      n_q          <= '0;
      row_q        <= '0;
      col_q        <= '0;
      dim_m_q[0]   <= '0;
      dim_m_q[1]   <= '0;
      dim_n_q[0]   <= '0;
      dim_n_q[1]   <= '0;
      slot_valid_q <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_q == W_IDLE && bus.wr_start) begin
        slot_q                     <= bus.wr_slot;
        m_q                        <= bus.wr_m;
        n_q                        <= bus.wr_n;
        row_q                      <= '0;
        col_q                      <= '0;
        slot_valid_q[bus.wr_slot]  <= 1'b0;
      end
      if (wr_fire) begin
        if (last_col) begin
          col_q <= '0;
          if (!last_row) row_q <= row_q + DIM_WIDTH'(1);
        end else begin
          col_q <= col_q + DIM_WIDTH'(1);
        end
      end
      if (state_q == W_DONE) begin
        dim_m_q[slot_q]      <= m_q;
        dim_n_q[slot_q]      <= n_q;
        slot_valid_q[slot_q] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[slot_q][wr_addr] <= bus.wr_elem;
  end

  // Rejected reads leave rd_elem at its last good value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_elem_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_ok;
      rd_err_q   <= bus.rd_en && !rd_ok;
      if (rd_ok) rd_elem_q <= mem[bus.rd_slot_idx][rd_addr];
    end
  end

  assign bus.wr_busy       = (state_q != W_IDLE);
  assign bus.wr_done       = (state_q == W_DONE);
  assign bus.wr_error      = (state_q == W_ERR);
  assign bus.rd_elem       = rd_elem_q;
  assign bus.rd_elem_valid = rd_valid_q;
  assign bus.rd_err        = rd_err_q;
  assign bus.slot_valid    = slot_valid_q;
  assign bus.q_m           = dim_m_q[bus.q_slot];
  assign bus.q_n           = dim_n_q[bus.q_slot];
endmodule
